// File: rtl/vector_line_rasterizer.sv
// vector_line_rasterizer: Bresenham line to frame-buffer pixel writes, one pixel per clock.
// Optional CLIP_EN: off-screen pixels are still stepped but their write strobe is suppressed.
module vector_line_rasterizer #(
    parameter int H_RES = 640,
    parameter int V_RES = 480,
    parameter int CW    = 11
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 line_valid,
    output logic                 line_ready,
    input  logic signed [CW-1:0] x0,
    input  logic signed [CW-1:0] y0,
    input  logic signed [CW-1:0] x1,
    input  logic signed [CW-1:0] y1,
    input  logic [3:0]           color,
    input  logic                 abort,
    output logic [18:0]          w_addr,
    output logic [3:0]           color_out,
    output logic                 en_w,
    output logic                 busy,
    output logic                 line_done
);
    localparam int W = 14;
    localparam logic signed [W-1:0] ONE = W'(1);
    localparam logic signed [W-1:0] HR  = W'(H_RES);
    localparam logic signed [W-1:0] VR  = W'(V_RES);

    typedef enum logic [1:0] {IDLE, SETUP, DRAW} state_t;
    state_t state, next_state;

    logic signed [W-1:0] cx, cy, ex, ey, dx, dy, sx, sy, err;
    logic signed [W-1:0] dx_c, dy_c, e2, nx, ny, nerr, px, py;
    logic [3:0]  color_r;
    logic [18:0] addr;
    logic        accept, last, step_x, step_y, emit, off;

    always_comb begin
        accept     = line_valid & line_ready & ~abort;
        dx_c       = (ex > cx) ? ex - cx : cx - ex;
        dy_c       = (ey > cy) ? cy - ey : ey - cy;
        e2         = err <<< 1;
        step_x     = e2 >= dy;
        step_y     = e2 <= dx;
        nx         = step_x ? cx + sx : cx;
        ny         = step_y ? cy + sy : cy;
        nerr       = err + (step_x ? dy : '0) + (step_y ? dx : '0);
        last       = (cx == ex) && (cy == ey);
        // SETUP emits the start point; DRAW emits the point it steps to
        px         = (state == DRAW) ? nx : cx;
        py         = (state == DRAW) ? ny : cy;
        addr       = 19'(py) * 19'(HR) + 19'(px);
        emit       = !abort && ((state == SETUP) || (state == DRAW && !last));
`ifdef CLIP_EN
        off        = (px < 0) || (px >= HR) || (py < 0) || (py >= VR);
`else
        off        = 1'b0;
`endif
        next_state = abort ? IDLE :
                     state == IDLE  ? (accept ? SETUP : IDLE) :
                     state == SETUP ? DRAW :
                     last ? IDLE : DRAW;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            w_addr     <= '0;
            color_out  <= '0;
            en_w       <= 1'b0;
            busy       <= 1'b0;
            line_done  <= 1'b0;
            line_ready <= 1'b0;
        end else begin
            en_w       <= 1'b0;
            line_done  <= (state == DRAW) && last && !abort;
            busy       <= next_state != IDLE;
            line_ready <= next_state == IDLE;
            if (accept) begin
                cx      <= W'(x0);
                cy      <= W'(y0);
                ex      <= W'(x1);
                ey      <= W'(y1);
                color_r <= color;
            end
            if (state == SETUP) begin
                dx  <= dx_c;
                dy  <= dy_c;
                sx  <= (ex > cx) ? ONE : -ONE;
                sy  <= (ey > cy) ? ONE : -ONE;
                err <= dx_c + dy_c;
            end
            if (state == DRAW) begin
                cx  <= nx;
                cy  <= ny;
                err <= nerr;
            end
            if (emit && !off) begin
                en_w      <= 1'b1;
                w_addr    <= addr;
                color_out <= color_r;
            end
        end
    end
endmodule

// File: tb/tb_vector_line_rasterizer.sv
// tb_vector_line_rasterizer: directed and random lines checked against an integer Bresenham model.
module tb_vector_line_rasterizer;
    logic clk = 1'b0, rst_n = 1'b0, line_valid = 1'b0, abort = 1'b0;
    logic signed [10:0] x0 = '0, y0 = '0, x1 = '0, y1 = '0;
    logic [3:0]  color = '0;
    logic        line_ready, en_w, busy, line_done;
    logic [18:0] w_addr;
    logic [3:0]  color_out;
    int n_cmp = 0, n_err = 0;
    int mx[$], my[$], obs[$];

    vector_line_rasterizer dut (
        .clk(clk), .rst_n(rst_n), .line_valid(line_valid), .line_ready(line_ready),
        .x0(x0), .y0(y0), .x1(x1), .y1(y1), .color(color), .abort(abort),
        .w_addr(w_addr), .color_out(color_out), .en_w(en_w), .busy(busy), .line_done(line_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int iabs(input int v);
        return v < 0 ? -v : v;
    endfunction

    // textbook integer Bresenham producing the full ordered pixel list
    function automatic void build(input int ax, input int ay, input int bx, input int by);
        int dx = iabs(bx - ax), dy = -iabs(by - ay);
        int sx = ax < bx ? 1 : -1, sy = ay < by ? 1 : -1;
        int err = dx + dy, x = ax, y = ay, e2;
        mx.delete();
        my.delete();
        for (int n = 0; n < 4096; n++) begin
            mx.push_back(x);
            my.push_back(y);
            if (x == bx && y == by) break;
            e2 = 2 * err;
            if (e2 >= dy) begin err += dy; x += sx; end
            if (e2 <= dx) begin err += dx; y += sy; end
        end
    endfunction

    function automatic bit visible(input int x, input int y);
`ifdef CLIP_EN
        return x >= 0 && x < 640 && y >= 0 && y < 480;
`else
        return 1'b1;
`endif
    endfunction

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input int ax, input int ay, input int bx, input int by, input int c);
        x0 = 11'(ax); y0 = 11'(ay); x1 = 11'(bx); y1 = 11'(by);
        color = 4'(c);
        line_valid = 1'b1;
        cycle();
        line_valid = 1'b0;
    endtask

    task automatic draw(input int ax, input int ay, input int bx, input int by, input int c, input string tag);
        bit on;
        build(ax, ay, bx, by);
        obs.delete();
        @(negedge clk);
        chk({tag, ".ready"}, int'(line_ready), 1);
        send(ax, ay, bx, by, c);
        chk({tag, ".setup_en"}, int'(en_w), 0);
        chk({tag, ".setup_busy"}, int'(busy), 1);
        foreach (mx[i]) begin
            cycle();
            on = visible(mx[i], my[i]);
            chk({tag, ".en_w"}, int'(en_w), int'(on));
            chk({tag, ".busy"}, int'(busy), 1);
            chk({tag, ".done_early"}, int'(line_done), 0);
            if (on) begin
                chk({tag, ".addr"}, int'(w_addr), my[i] * 640 + mx[i]);
                chk({tag, ".color"}, int'(color_out), c);
            end
            obs.push_back(en_w ? int'(w_addr) : -1);
        end
        cycle();
        chk({tag, ".done"}, int'(line_done), 1);
        chk({tag, ".done_en"}, int'(en_w), 0);
        chk({tag, ".done_ready"}, int'(line_ready), 1);
        chk({tag, ".done_busy"}, int'(busy), 0);
        cycle();
        chk({tag, ".done_pulse"}, int'(line_done), 0);
    endtask

    initial begin
        int exp1[5] = '{3210, 3211, 3212, 3213, 3214};
        int exp2[7] = '{0, 640, 1281, 1921, 2561, 3202, 3842};
        int exp3[4] = '{1923, 1282, 641, 0};
        repeat (3) @(negedge clk);
        chk("rst.en_w", int'(en_w), 0);
        chk("rst.busy", int'(busy), 0);
        chk("rst.ready", int'(line_ready), 0);
        chk("rst.addr", int'(w_addr), 0);
        chk("rst.done", int'(line_done), 0);
        chk("rst.color", int'(color_out), 0);
        rst_n = 1'b1;
        cycle();
        chk("rel.ready", int'(line_ready), 1);

        draw(10, 5, 14, 5, 3, "horiz");
        chk("horiz.count", obs.size(), 5);
        foreach (exp1[i]) chk("horiz.seq", obs[i], exp1[i]);
        draw(0, 0, 2, 6, 9, "steep");
        chk("steep.count", obs.size(), 7);
        foreach (exp2[i]) chk("steep.seq", obs[i], exp2[i]);
        draw(3, 3, 0, 0, 12, "rdiag");
        chk("rdiag.count", obs.size(), 4);
        foreach (exp3[i]) chk("rdiag.seq", obs[i], exp3[i]);
        draw(7, 7, 7, 7, 1, "zero");
        chk("zero.count", obs.size(), 1);
        chk("zero.seq", obs[0], 4487);
`ifdef CLIP_EN
        draw(-2, 0, 2, 0, 6, "clip");
        chk("clip.count", obs.size(), 5);
        chk("clip.p0", obs[0], -1);
        chk("clip.p2", obs[2], 0);
        chk("clip.p4", obs[4], 2);
`endif

        @(negedge clk);
        send(0, 10, 19, 10, 5);
        repeat (3) cycle();
        chk("abort.pix3", int'(w_addr), 6402);
        abort = 1'b1;
        cycle();
        abort = 1'b0;
        chk("abort.en_w", int'(en_w), 0);
        chk("abort.busy", int'(busy), 0);
        chk("abort.ready", int'(line_ready), 1);
        chk("abort.done", int'(line_done), 0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("abort.no_done", int'(line_done), 0);
            chk("abort.quiet", int'(en_w), 0);
        end
        line_valid = 1'b1;
        abort = 1'b1;
        x0 = 11'(1); y0 = 11'(1); x1 = 11'(5); y1 = 11'(1);
        cycle();
        line_valid = 1'b0;
        abort = 1'b0;
        chk("abort_idle.busy", int'(busy), 0);
        chk("abort_idle.ready", int'(line_ready), 1);
        cycle();
        chk("abort_idle.busy2", int'(busy), 0);
        chk("abort_idle.en_w", int'(en_w), 0);

        for (int k = 0; k < 40; k++) begin
            int ax = $urandom_range(639), ay = $urandom_range(479);
            int bx = $urandom_range(639), by = $urandom_range(479);
            if (k % 2 == 0) begin
                bx = ax + $urandom_range(40) - 20;
                by = ay + $urandom_range(40) - 20;
                bx = bx < 0 ? 0 : bx > 639 ? 639 : bx;
                by = by < 0 ? 0 : by > 479 ? 479 : by;
            end
            draw(ax, ay, bx, by, $urandom_range(15), "rand");
        end

        @(negedge clk);
        send(0, 0, 100, 50, 7);
        repeat (4) cycle();
        rst_n = 1'b0;
        cycle();
        chk("midrst.en_w", int'(en_w), 0);
        chk("midrst.busy", int'(busy), 0);
        chk("midrst.ready", int'(line_ready), 0);
        chk("midrst.addr", int'(w_addr), 0);
        chk("midrst.done", int'(line_done), 0);
        rst_n = 1'b1;
        cycle();
        chk("midrst.rel_ready", int'(line_ready), 1);
        draw(300, 200, 290, 230, 11, "after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
